// File: rtl/me_mem_subsystem.sv
// Motion-estimation pixel store: 16x16 reference block plus 32x32 search window,
// one reference read port and two independent search read ports, all latency 1.
module me_mem_subsystem #(
    parameter int DATA_W = 8,
    parameter int R_AW   = 8,
    parameter int S_AW   = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              r_we,
    input  logic [R_AW-1:0]   r_waddr,
    input  logic [DATA_W-1:0] r_wdata,
    input  logic              s_we,
    input  logic [S_AW-1:0]   s_waddr,
    input  logic [DATA_W-1:0] s_wdata,
    input  logic [R_AW-1:0]   AddressR,
    input  logic [S_AW-1:0]   AddressS1,
    input  logic [S_AW-1:0]   AddressS2,
    output logic [DATA_W-1:0] R,
    output logic [DATA_W-1:0] S1,
    output logic [DATA_W-1:0] S2
);
    localparam int R_DEPTH = 1 << R_AW;
    localparam int S_DEPTH = 1 << S_AW;
    localparam int NUM_RD  = 2;

    logic [DATA_W-1:0] ref_mem  [R_DEPTH];
    logic [DATA_W-1:0] srch_mem [S_DEPTH];

    logic [NUM_RD-1:0][S_AW-1:0]   s_raddr;
    logic [NUM_RD-1:0][DATA_W-1:0] s_rdata;

    assign s_raddr = {AddressS2, AddressS1};

    // Storage has no reset: writes land even while reset is held.
    always_ff @(posedge clock) begin
        if (r_we) ref_mem[r_waddr]  <= r_wdata;
        if (s_we) srch_mem[s_waddr] <= s_wdata;
    end

    // Nonblocking reads of the arrays give read-old-data on a same-address write.
    always_ff @(posedge clock) begin
        if (reset) begin
            R       <= '0;
            s_rdata <= '0;
        end else begin
            R <= ref_mem[AddressR];
            for (int p = 0; p < NUM_RD; p++)
                s_rdata[p] <= srch_mem[s_raddr[p]];
        end
    end

    assign S1 = s_rdata[0];
    assign S2 = s_rdata[1];
endmodule

// File: tb/tb_me_mem_subsystem.sv
// Directed + randomized bench for me_mem_subsystem against an array-based memory model.
module tb_me_mem_subsystem;
    logic       clock = 1'b0;
    logic       reset;
    logic       r_we;
    logic [7:0] r_waddr, r_wdata;
    logic       s_we;
    logic [9:0] s_waddr;
    logic [7:0] s_wdata;
    logic [7:0] AddressR;
    logic [9:0] AddressS1, AddressS2;
    logic [7:0] R, S1, S2;

    int errors = 0;
    int checks = 0;

    // Reference model: plain arrays plus a written-flag per word.
    logic [7:0] rm [256];
    bit         rv [256];
    logic [7:0] sm [1024];
    bit         sv [1024];

    me_mem_subsystem #(.DATA_W(8), .R_AW(8), .S_AW(10)) dut (
        .clock(clock), .reset(reset),
        .r_we(r_we), .r_waddr(r_waddr), .r_wdata(r_wdata),
        .s_we(s_we), .s_waddr(s_waddr), .s_wdata(s_wdata),
        .AddressR(AddressR), .AddressS1(AddressS1), .AddressS2(AddressS2),
        .R(R), .S1(S1), .S2(S2)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: predict outputs from current inputs, update model, step, compare.
    task automatic cyc();
        logic [7:0] er, e1, e2;
        bit kr, k1, k2;
        if (reset) begin
            er = 8'h00; e1 = 8'h00; e2 = 8'h00;
            kr = 1'b1;  k1 = 1'b1;  k2 = 1'b1;
        end else begin
            er = rm[AddressR];  kr = rv[AddressR];
            e1 = sm[AddressS1]; k1 = sv[AddressS1];
            e2 = sm[AddressS2]; k2 = sv[AddressS2];
        end
        if (r_we) begin rm[r_waddr] = r_wdata; rv[r_waddr] = 1'b1; end
        if (s_we) begin sm[s_waddr] = s_wdata; sv[s_waddr] = 1'b1; end
        @(posedge clock);
        #1;
        if (kr) chk("R", R, er);
        if (k1) chk("S1", S1, e1);
        if (k2) chk("S2", S2, e2);
    endtask

    initial begin
        reset = 1'b1; r_we = 1'b0; s_we = 1'b0;
        r_waddr = '0; r_wdata = '0; s_waddr = '0; s_wdata = '0;
        AddressR = '0; AddressS1 = '0; AddressS2 = '0;
        for (int i = 0; i < 256; i++) rv[i] = 1'b0;
        for (int i = 0; i < 1024; i++) sv[i] = 1'b0;

        // Reset state: outputs zero.
        cyc();
        cyc();
        reset = 1'b0;

        // Reference write then read, latency exactly one.
        r_we = 1'b1; r_waddr = 8'h00; r_wdata = 8'h3C; cyc();
        r_waddr = 8'h05; r_wdata = 8'hA5; cyc();
        r_we = 1'b0; AddressR = 8'h00; cyc();
        AddressR = 8'h05;
        #1 chk("R_early", R, 8'h3C);
        cyc();
        cyc();

        // Search corners on both ports, then swapped.
        s_we = 1'b1; s_waddr = 10'h000; s_wdata = 8'h11; cyc();
        s_waddr = 10'h3FF; s_wdata = 8'hEE; cyc();
        s_we = 1'b0; AddressS1 = 10'h000; AddressS2 = 10'h3FF; cyc();
        chk("S1_corner", S1, 8'h11);
        chk("S2_corner", S2, 8'hEE);
        AddressS1 = 10'h3FF; AddressS2 = 10'h000; cyc();
        chk("S1_swap", S1, 8'hEE);
        chk("S2_swap", S2, 8'h11);

        // Read-during-write returns old data, new data next cycle.
        s_we = 1'b1; s_waddr = 10'h020; s_wdata = 8'h33; cyc();
        s_wdata = 8'h44; AddressS1 = 10'h020; cyc();
        chk("S1_rdw_old", S1, 8'h33);
        s_we = 1'b0; cyc();
        chk("S1_rdw_new", S1, 8'h44);

        // Full load with addr^0x5A, then sweep all three ports.
        for (int i = 0; i < 1024; i++) begin
            s_we = 1'b1; s_waddr = i[9:0]; s_wdata = i[7:0] ^ 8'h5A;
            r_we = (i < 256); r_waddr = i[7:0]; r_wdata = i[7:0] ^ 8'h5A;
            cyc();
        end
        r_we = 1'b0; s_we = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            AddressR = i[7:0]; AddressS1 = i[9:0]; AddressS2 = 10'(1023 - i);
            cyc();
        end
        cyc();

        // Reset with outputs nonzero and a write pending in the reset cycle.
        AddressR = 8'h01; AddressS1 = 10'h002; AddressS2 = 10'h003; cyc();
        chk("R_pre_rst", R, 8'h5B);
        reset = 1'b1; r_we = 1'b1; r_waddr = 8'h10; r_wdata = 8'h77;
        cyc();
        chk("R_rst", R, 8'h00);
        chk("S1_rst", S1, 8'h00);
        chk("S2_rst", S2, 8'h00);
        reset = 1'b0; r_we = 1'b0; AddressR = 8'h10; cyc();
        chk("R_after_rst", R, 8'h77);
        chk("S1_intact", S1, 8'h58);

        // Randomized mix: collisions, shared search address, occasional reset.
        for (int n = 0; n < 400; n++) begin
            AddressR  = 8'($urandom_range(0, 255));
            AddressS1 = 10'($urandom_range(0, 1023));
            AddressS2 = ($urandom_range(0, 3) == 0) ? AddressS1 : 10'($urandom_range(0, 1023));
            r_we    = 1'($urandom_range(0, 1));
            r_waddr = ($urandom_range(0, 2) == 0) ? AddressR : 8'($urandom_range(0, 255));
            r_wdata = 8'($urandom);
            s_we    = 1'($urandom_range(0, 1));
            s_waddr = ($urandom_range(0, 2) == 0) ? AddressS2 : 10'($urandom_range(0, 1023));
            s_wdata = 8'($urandom);
            reset   = ($urandom_range(0, 19) == 0);
            cyc();
        end
        reset = 1'b0; r_we = 1'b0; s_we = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/me_mem_subsystem.md
ME_MEM_SUBSYSTEM -- requirements
Module: me_mem_subsystem

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, pixel width in bits.
REQ-002 The block SHALL have parameter R_AW, default 8, reference-block address width (256 pixels, 16x16).
REQ-003 The block SHALL have parameter S_AW, default 10, search-window address width (1024 pixels, 32x32 grid holding the 31x31 window).
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 r_we  input  1  write enable, reference memory.
REQ-007 r_waddr  input  R_AW  reference write address.
REQ-008 r_wdata  input  DATA_W  reference write data.
REQ-009 s_we  input  1  write enable, search memory.
REQ-010 s_waddr  input  S_AW  search write address.
REQ-011 s_wdata  input  DATA_W  search write data.
REQ-012 AddressR  input  R_AW  reference read address.
REQ-013 AddressS1  input  S_AW  search read address, port 1.
REQ-014 AddressS2  input  S_AW  search read address, port 2.
REQ-015 R  output  DATA_W  reference read data.
REQ-016 S1  output  DATA_W  search read data, port 1.
REQ-017 S2  output  DATA_W  search read data, port 2.

Function
REQ-018 Reference memory SHALL hold 2^R_AW words of DATA_W bits; pixel (row,col) at address row*16+col.
REQ-019 Search memory SHALL hold 2^S_AW words of DATA_W bits; pixel (row,col) at address row*32+col; row/col 31 unused by the motion estimator but fully readable and writable.
REQ-020 With r_we=1 at a rising edge, ref[r_waddr] SHALL take r_wdata; with s_we=1, srch[s_waddr] SHALL take s_wdata; both writes may occur in the same cycle.
REQ-021 Reads SHALL be synchronous with latency 1: R, S1, S2 at edge N+1 reflect the addresses sampled at edge N.
REQ-022 S1 and S2 SHALL read independently; equal AddressS1 and AddressS2 SHALL return the same word on both ports.
REQ-023 Read-during-write to the same address in the same cycle SHALL return the old (pre-write) data; the new data SHALL be visible from the next read.
REQ-024 Outputs SHALL hold their last value while addresses are unchanged and no relevant write occurs; every address in full 0..2^AW-1 range is valid, no wrap or out-of-range handling.
REQ-025 Writes SHALL have no effect on R, S1, S2 in the write cycle except through REQ-023.
REQ-026 Memory contents SHALL be undefined (X in simulation) until written; the block SHALL NOT contain initial-content loading.

Reset
REQ-027 While reset=1 at a rising edge, R, S1, S2 SHALL be driven to 0 at that edge.
REQ-028 Reset SHALL NOT alter memory contents; writes requested in a reset cycle SHALL still be performed.
REQ-029 Reads SHALL resume on the first edge with reset=0, producing data for the address sampled at that edge one cycle later.
REQ-030 Reset asserted mid-read-sequence SHALL zero outputs at the next edge and discard the in-flight read.

Verification
REQ-031 Write ref[0x05]=0xA5, then AddressR=0x05 -> R=0xA5 exactly one cycle after address applied, not before.
REQ-032 Write srch[0x000]=0x11, srch[0x3FF]=0xEE; AddressS1=0x000, AddressS2=0x3FF -> next cycle S1=0x11, S2=0xEE; swap addresses -> S1=0xEE, S2=0x11.
REQ-033 srch[0x020]=0x33, then same cycle s_we=1, s_waddr=0x020, s_wdata=0x44, AddressS1=0x020 -> S1=0x33 next cycle, S1=0x44 cycle after.
REQ-034 Load 256 ref and 1024 srch words with value addr[7:0]^0x5A, sweep all addresses on all three ports -> every read matches, latency 1.
REQ-035 Outputs nonzero, assert reset one cycle with r_we writing ref[0x10]=0x77 -> R,S1,S2=0 after edge; after release, AddressR=0x10 -> R=0x77, earlier loaded data intact.
